// File: rtl/raster_pkg.sv
// Shared rasteriser definitions: FSM encodings, default widths and the queue entry width.
package raster_pkg;

    localparam int unsigned DEF_WIDTH        = 8;
    localparam int unsigned DEF_COLOUR_WIDTH = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    // One queue entry is {ax, ay, bx, by, cx, cy, colour}.
    function automatic int unsigned entry_w(int unsigned width, int unsigned colour_width);
        return 6 * width + colour_width;
    endfunction

endpackage

// File: rtl/triangle_queue_if.sv
// Triangle handshake from the geometry/projection stage into triangle_queue.
interface triangle_queue_if import raster_pkg::*; #(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned COLOUR_WIDTH = DEF_COLOUR_WIDTH
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_ax, in_ay, in_bx, in_by, in_cx, in_cy;
    logic [COLOUR_WIDTH-1:0] in_colour;

    modport master (
        output in_valid, in_ax, in_ay, in_bx, in_by, in_cx, in_cy, in_colour,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_ax, in_ay, in_bx, in_by, in_cx, in_cy, in_colour,
        output in_ready
    );

endinterface

// File: rtl/triangle_queue_sync_fifo.sv
// Single-clock circular-buffer FIFO; head entry is visible on rdata whenever not empty.
module sync_fifo #(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata;
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/triangle_queue.sv
// Triangle command buffer: queues triangles and issues them one at a time to draw_triangle,
// tracking each draw through the screen_start/screen_done pass.
module triangle_queue import raster_pkg::*; #(
    parameter  int unsigned WIDTH        = DEF_WIDTH,
    parameter  int unsigned COLOUR_WIDTH = DEF_COLOUR_WIDTH,
    parameter  int unsigned DEPTH        = 8,
    localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    triangle_queue_if.slave         in_if,
    output logic [WIDTH-1:0]        ax,
    output logic [WIDTH-1:0]        ay,
    output logic [WIDTH-1:0]        bx,
    output logic [WIDTH-1:0]        by,
    output logic [WIDTH-1:0]        cx,
    output logic [WIDTH-1:0]        cy,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    draw_en,
    input  logic                    screen_start,
    input  logic                    screen_done,
    output logic [CNT_W-1:0]        count,
    output logic                    busy
);

    localparam int unsigned EW = entry_w(WIDTH, COLOUR_WIDTH);

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] out_q, out_d;
    logic          draw_en_q, draw_en_d;
    logic          busy_q, busy_d;
    logic [EW-1:0] head;
    logic          push, pop, full, empty;

    assign in_if.in_ready = !reset && !full;
    assign push           = in_if.in_valid && in_if.in_ready;

    sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({in_if.in_ax, in_if.in_ay, in_if.in_bx, in_if.in_by,
                 in_if.in_cx, in_if.in_cy, in_if.in_colour}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (screen_start) state_d = S_DRAW;
            end
            S_DRAW: begin
                // Back-to-back issue: the next pop happens on the screen_done edge itself.
                if (screen_done) begin
                    pop     = !empty;
                    state_d = empty ? S_IDLE : S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        out_d     = pop ? head : out_q;
        draw_en_d = (state_d == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            draw_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            draw_en_q <= draw_en_d;
            busy_q    <= busy_d;
        end
    end

    assign {ax, ay, bx, by, cx, cy, colour} = out_q;
    assign draw_en = draw_en_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_triangle_queue.sv
// Self-checking bench for triangle_queue: directed table, corner sequences, random vs model.
module tb_triangle_queue;
    import raster_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned D    = 8;
    localparam int unsigned CNTW = $clog2(D) + 1;

    typedef struct packed {
        logic [W-1:0]  ax, ay, bx, by, cx, cy;
        logic [CW-1:0] col;
    } trig_t;

    typedef struct {
        bit    rst, vld;
        trig_t t;
        bit    ss, sd;
        bit    e_den, e_busy;
        int    e_cnt;
        bit    e_rdy;
        int    e_ax, e_col;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            screen_start = 1'b0;
    logic            screen_done = 1'b0;
    logic [W-1:0]    ax, ay, bx, by, cx, cy;
    logic [CW-1:0]   colour;
    logic            draw_en, busy;
    logic [CNTW-1:0] count;
    trig_t           dut_out;

    always #5 clock = ~clock;

    triangle_queue_if #(.WIDTH(W), .COLOUR_WIDTH(CW)) in_if ();

    triangle_queue #(
        .WIDTH        (W),
        .COLOUR_WIDTH (CW),
        .DEPTH        (D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_if        (in_if),
        .ax           (ax),
        .ay           (ay),
        .bx           (bx),
        .by           (by),
        .cx           (cx),
        .cy           (cy),
        .colour       (colour),
        .draw_en      (draw_en),
        .screen_start (screen_start),
        .screen_done  (screen_done),
        .count        (count),
        .busy         (busy)
    );

    assign dut_out = {ax, ay, bx, by, cx, cy, colour};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue, the triangle last handed out, and where the draw stands.
    trig_t mq[$];
    trig_t m_out = '0;
    bit    m_flight = 1'b0;
    bit    m_started = 1'b0;

    function automatic trig_t mk_tri(int a0, int a1, int b0, int b1, int c0, int c1, int col);
        trig_t t;
        t.ax = W'(a0); t.ay = W'(a1); t.bx = W'(b0); t.by = W'(b1);
        t.cx = W'(c0); t.cy = W'(c1); t.col = CW'(col);
        return t;
    endfunction

    function automatic trig_t rnd_tri();
        return mk_tri($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endfunction

    function automatic vec_t mk(bit rst, bit vld, trig_t t, bit ss, bit sd, bit e_den,
                                bit e_busy, int e_cnt, bit e_rdy, int e_ax, int e_col);
        vec_t v;
        v.rst = rst; v.vld = vld; v.t = t; v.ss = ss; v.sd = sd;
        v.e_den = e_den; v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        v.e_ax = e_ax; v.e_col = e_col;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst, bit vld, trig_t t, bit ss, bit sd);
        reset           = rst;
        in_if.in_valid  = vld;
        in_if.in_ax     = t.ax;
        in_if.in_ay     = t.ay;
        in_if.in_bx     = t.bx;
        in_if.in_by     = t.by;
        in_if.in_cx     = t.cx;
        in_if.in_cy     = t.cy;
        in_if.in_colour = t.col;
        screen_start    = ss;
        screen_done     = sd;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit    acc;
        bit    do_pop;
        trig_t t;
        if (reset) begin
            mq.delete();
            m_out     = '0;
            m_flight  = 1'b0;
            m_started = 1'b0;
        end else begin
            acc    = in_if.in_valid && (mq.size() < D);
            t      = {in_if.in_ax, in_if.in_ay, in_if.in_bx, in_if.in_by,
                      in_if.in_cx, in_if.in_cy, in_if.in_colour};
            do_pop = 1'b0;
            if (!m_flight) begin
                do_pop = (mq.size() > 0);
            end else if (!m_started) begin
                m_started = screen_start;
            end else if (screen_done) begin
                if (mq.size() > 0) do_pop = 1'b1;
                else m_flight = 1'b0;
            end
            if (do_pop) begin
                m_out     = mq.pop_front();
                m_flight  = 1'b1;
                m_started = 1'b0;
            end
            if (acc) mq.push_back(t);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".draw_en"}, 64'(draw_en), 64'(m_flight && !m_started));
        chk({tag, ".busy"}, 64'(busy), 64'(m_flight));
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".in_ready"}, 64'(in_if.in_ready), 64'(!reset && (mq.size() < D)));
        chk({tag, ".outputs"}, 64'(dut_out), 64'(m_out));
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 2 * D + 4; i++) begin
            drive(0, 0, '0, 1, 0); tick(); check_all(tag);
            drive(0, 0, '0, 0, 1); tick(); check_all(tag);
        end
    endtask

    task automatic do_reset();
        drive(1, 0, '0, 0, 0); tick(); check_all("reset");
        drive(0, 0, '0, 0, 0);
    endtask

    vec_t  tbl[11];
    trig_t ta, tb, tz, tx;
    trig_t tr[5];

    initial begin
        ta = mk_tri(125, 34, 80, 60, 0, 0, 7);
        tb = mk_tri(10, 20, 30, 40, 50, 60, 2);
        tz = '0;
        //             rst vld tri ss sd | den busy cnt rdy ax  col
        tbl[0]  = mk(1, 0, tz, 0, 0,  0, 0, 0, 0, 0,   0);
        tbl[1]  = mk(0, 1, ta, 0, 0,  0, 0, 1, 1, 0,   0);
        tbl[2]  = mk(0, 0, tz, 0, 0,  1, 1, 0, 1, 125, 7);
        tbl[3]  = mk(0, 0, tz, 0, 0,  1, 1, 0, 1, 125, 7);
        tbl[4]  = mk(0, 0, tz, 0, 1,  1, 1, 0, 1, 125, 7);
        tbl[5]  = mk(0, 0, tz, 1, 0,  0, 1, 0, 1, 125, 7);
        tbl[6]  = mk(0, 1, tb, 1, 0,  0, 1, 1, 1, 125, 7);
        tbl[7]  = mk(0, 0, tz, 0, 1,  1, 1, 0, 1, 10,  2);
        tbl[8]  = mk(0, 0, tz, 1, 0,  0, 1, 0, 1, 10,  2);
        tbl[9]  = mk(0, 0, tz, 0, 1,  0, 0, 0, 1, 10,  2);
        tbl[10] = mk(0, 0, tz, 0, 0,  0, 0, 0, 1, 10,  2);

        drive(1, 0, tz, 0, 0);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].t, tbl[i].ss, tbl[i].sd);
            tick();
            chk($sformatf("tbl%0d.draw_en", i), 64'(draw_en), 64'(tbl[i].e_den));
            chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.in_ready", i), 64'(in_if.in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.ax", i), 64'(ax), 64'(tbl[i].e_ax));
            chk($sformatf("tbl%0d.colour", i), 64'(colour), 64'(tbl[i].e_col));
        end

        // Fill to capacity while draw_triangle stalls, then hold a push off until a pop.
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(0, 1, rnd_tri(), 0, 0); tick(); check_all("fill");
        end
        chk("fill.count7", 64'(count), 64'(D - 1));
        drive(0, 1, rnd_tri(), 0, 0); tick(); check_all("fill9");
        chk("full.count", 64'(count), 64'(D));
        chk("full.in_ready", 64'(in_if.in_ready), 64'd0);
        tx = rnd_tri();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, tx, 0, 0); tick(); check_all("held");
            chk("held.count", 64'(count), 64'(D));
        end
        drive(0, 1, tx, 1, 0); tick(); check_all("held_start");
        drive(0, 1, tx, 0, 1); tick(); check_all("held_pop");
        chk("held_pop.count", 64'(count), 64'(D - 1));
        chk("held_pop.in_ready", 64'(in_if.in_ready), 64'd1);
        drive(0, 1, tx, 0, 0); tick(); check_all("held_push");
        chk("held_push.count", 64'(count), 64'(D));
        drain("fill_drain");

        // Back-to-back issue in FIFO order, with a push landing on a pop edge at count=3.
        do_reset();
        for (int i = 0; i < 5; i++) tr[i] = rnd_tri();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, tr[i], 0, 0); tick(); check_all("b2b_fill");
        end
        chk("b2b.count3", 64'(count), 64'd3);
        chk("b2b.first", 64'(dut_out), 64'(tr[0]));
        drive(0, 0, tz, 1, 0); tick(); check_all("b2b_start");
        drive(0, 1, tr[4], 0, 1); tick(); check_all("b2b_pushpop");
        chk("pushpop.count", 64'(count), 64'd3);
        chk("pushpop.draw_en", 64'(draw_en), 64'd1);
        chk("pushpop.out", 64'(dut_out), 64'(tr[1]));
        for (int k = 2; k < 5; k++) begin
            drive(0, 0, tz, 1, 0); tick(); check_all("b2b_start");
            drive(0, 0, tz, 0, 1); tick(); check_all("b2b_done");
            chk($sformatf("b2b%0d.draw_en", k), 64'(draw_en), 64'd1);
            chk($sformatf("b2b%0d.out", k), 64'(dut_out), 64'(tr[k]));
            chk($sformatf("b2b%0d.count", k), 64'(count), 64'(4 - k));
        end
        drive(0, 0, tz, 1, 0); tick(); check_all("b2b_last");
        drive(0, 0, tz, 0, 1); tick(); check_all("b2b_last");
        chk("b2b.idle_busy", 64'(busy), 64'd0);

        // Reset mid-draw abandons the in-flight triangle and empties the queue.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, rnd_tri(), 0, 0); tick(); check_all("mid_fill");
        end
        chk("mid.count4", 64'(count), 64'd4);
        drive(0, 0, tz, 1, 0); tick(); check_all("mid_draw");
        drive(1, 0, tz, 0, 0); tick();
        chk("midrst.draw_en", 64'(draw_en), 64'd0);
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.outputs", 64'(dut_out), 64'd0);
        model_step();
        tx = rnd_tri();
        drive(0, 1, tx, 0, 0); tick(); check_all("post_rst");
        drive(0, 0, tz, 0, 0); tick(); check_all("post_rst");
        chk("post_rst.draw_en", 64'(draw_en), 64'd1);
        chk("post_rst.out", 64'(dut_out), 64'(tx));
        drain("post_rst_drain");

        // Random traffic, spurious screen_* pulses and occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, rnd_tri(),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
            tick();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_queue.md
# triangle_queue

Triangle command buffer sitting directly upstream of `draw_triangle`. Accepts triangles (three vertices plus colour) from the geometry/projection stage over a valid/ready handshake and stores up to DEPTH of them. Issues them one at a time to `draw_triangle` via `draw_en`. Tracks each draw's bounding-box pass through the `screen_start`/`screen_done` signals exchanged with `screen_writer`, so only one triangle is ever in flight.

## Interface
Parameters:
- WIDTH, 8, coordinate width (matches `draw_triangle`/`screen_writer`)
- COLOUR_WIDTH, 3, colour width
- DEPTH, 8, queue entries; power of two, ≥2

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high; sampled on posedge clock
- in_valid  in  1  producer has a triangle on in_*
- in_ready  out  1  queue can accept (count < DEPTH and reset low)
- in_ax, in_ay, in_bx, in_by, in_cx, in_cy  in  WIDTH each  vertex coordinates
- in_colour  in  COLOUR_WIDTH  fill colour
- ax, ay, bx, by, cx, cy  out  WIDTH each  to `draw_triangle`; registered
- colour  out  COLOUR_WIDTH  to `draw_triangle`; registered
- draw_en  out  1  draw request to `draw_triangle`; registered
- screen_start  in  1  tapped from `draw_triangle` → `screen_writer`
- screen_done  in  1  tapped from `screen_writer` → `draw_triangle`
- count  out  $clog2(DEPTH)+1  triangles queued, excluding the one in flight
- busy  out  1  high whenever state ≠ S_IDLE

## Operation
- Storage: circular buffer with rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and count.
  - Entry = {ax, ay, bx, by, cx, cy, colour}, i.e. 6·WIDTH+COLOUR_WIDTH bits.
- Push: in_valid && in_ready at a posedge writes the entry at wr_ptr, then wr_ptr++ and count++.
- Pop: loads the head entry into the output registers, then rd_ptr++ and count--.
- Push and pop on the same edge are both performed; count is unchanged.
- FSM states:
  - S_IDLE: draw_en=0. If count>0, pop and go to S_ISSUE.
  - S_ISSUE: draw_en=1. Stay until screen_start sampled 1, then go to S_DRAW (draw_en=0 from that edge).
  - S_DRAW: draw_en=0. When screen_done is sampled 1:
    - if count>0, pop and go to S_ISSUE (back-to-back issue);
    - otherwise go to S_IDLE.
- `draw_triangle` produces exactly one screen_start/screen_done pass per accepted draw_en, including for degenerate triangles.
- screen_start in S_IDLE/S_DRAW is ignored.
- screen_done in S_IDLE/S_ISSUE is ignored.
- Outputs ax..colour are held stable from the pop until the next pop, including through S_IDLE.
- Push while full: in_ready=0, so no write occurs and no state changes.
- Push while empty and idle: no bypass path; the entry goes through the buffer.

## Timing
- Reset values:
  - state=S_IDLE, rd_ptr=wr_ptr=0, count=0
  - draw_en=0, busy=0
  - ax..cy=0, colour=0
  - in_ready=0 while reset is high, 1 on the first cycle after reset.
- Reset mid-draw: the queue is emptied and the in-flight triangle is abandoned; draw_en=0 on the cycle after the reset edge. Downstream shares the same reset.
- Latency: push accepted at edge E0 → pop at E1 → draw_en=1 and outputs valid in the cycle after E1.
- Back-to-back issue:
  - screen_done sampled at edge E → next triangle's outputs and draw_en=1 valid in the cycle after E.
  - Zero idle cycles between triangles.
- in_ready is combinational from count and reset only; it never depends on in_valid.
- count and busy are registered.

## Structure
- Shared package (`raster_pkg`):
  - state encodings S_IDLE/S_ISSUE/S_DRAW
  - ENTRY_W function of WIDTH/COLOUR_WIDTH
  - default WIDTH=8 and COLOUR_WIDTH=3
- Sub-module `sync_fifo`:
  - parameterised data width and DEPTH
  - push/pop/count/full/empty, synchronous active-high reset
- `triangle_queue` = `sync_fifo` + FSM + output registers.

## Test plan
- Reset, then push one triangle (125,34),(80,60),(0,0), colour 3'b111 → draw_en=1 two cycles after the push edge with those outputs; screen_start → draw_en=0; screen_done → busy=0, count=0.
- Push 8 triangles while holding screen_start low → 1 popped, count=7; push 1 more → count=8, in_ready=0; a 10th push with in_valid is held off until the next pop.
- Three queued triangles, screen_done pulses each pass → draw_en re-asserts the cycle after each screen_done, outputs advance in FIFO order, no idle cycles.
- Push on the same edge as a pop with count=3 → count stays 3, pushed entry is issued last.
- Spurious screen_done in S_ISSUE and spurious screen_start in S_DRAW → no state change, draw_en and outputs unchanged.
- Reset asserted in S_DRAW with count=4 → next cycle: draw_en=0, count=0, busy=0, outputs 0; a later push is issued normally.
